vsn_sparam_coef_loader: RTL

- Upstream configuration stage for the 3-port S-parameter datapath.
- Accepts individual S-matrix coefficient writes into a shadow bank, then copies the shadow bank into the active bank at a datapath frame boundary.
- The active bank drives the S[i][j] inputs of the S-parameter combiner, so coefficients never change mid-frame.

---
 rtl/vsn_sparam_coef_loader_if.sv | 15 +
 rtl/vsn_sparam_coef_loader.sv | 114 +++++++++++
 2 files changed

// File: rtl/vsn_sparam_coef_loader_if.sv
// Coefficient write channel for the S-parameter coefficient loader.
// The master drives valid/addr/data; the slave returns ready.
`timescale 1ns/1ps
interface vsn_sparam_coef_loader_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int COEF_WIDTH = 16
);
  logic                          wr_valid;
  logic                          wr_ready;
  logic        [ADDR_WIDTH-1:0]  wr_addr;
  logic signed [COEF_WIDTH-1:0]  wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/vsn_sparam_coef_loader.sv
// Shadow/active S-matrix coefficient bank with frame-aligned commit.
// Optional readback port enabled by defining VSN_SPARAM_COEF_READBACK_EN.
`timescale 1ns/1ps
module vsn_sparam_coef_loader #(
  parameter int COEF_WIDTH = 16,
  parameter int NPORTS     = 3,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  vsn_sparam_coef_loader_if.slave                wr,
  input  logic                                   commit_req,
  input  logic                                   frame_strobe,
  output logic                                   commit_ack,
  output logic                                   s_update,
  output logic                                   busy,
  output logic                                   err_addr,
`ifdef VSN_SPARAM_COEF_READBACK_EN
  input  logic        [ADDR_WIDTH-1:0]           rd_addr,
  output logic signed [COEF_WIDTH-1:0]           rd_data,
`endif
  output logic [NPORTS*NPORTS*COEF_WIDTH-1:0]    s_flat
);

  localparam int NN = NPORTS * NPORTS;

  typedef enum logic [1:0] {IDLE, PENDING, ACK} state_t;

  state_t                       state;
  logic                         wr_ready_q;
  logic                         wr_fire;
  logic                         wr_in_range;
  logic signed [COEF_WIDTH-1:0] shadow [NN];
  logic signed [COEF_WIDTH-1:0] active [NN];

  assign wr.wr_ready = wr_ready_q;
  assign wr_fire     = wr.wr_valid && wr_ready_q;

  always_comb begin
    wr_in_range = 1'b0;
    for (int k = 0; k < NN; k++)
      if (wr.wr_addr == ADDR_WIDTH'(k)) wr_in_range = 1'b1;
  end

  // Control and both banks; a write accepted on the commit_req edge lands before the copy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      wr_ready_q <= 1'b1;
      busy       <= 1'b0;
      commit_ack <= 1'b0;
      s_update   <= 1'b0;
      err_addr   <= 1'b0;
      for (int k = 0; k < NN; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      commit_ack <= 1'b0;
      s_update   <= 1'b0;
      if (wr_fire) begin
        if (!wr_in_range) err_addr <= 1'b1;
        for (int k = 0; k < NN; k++)
          if (wr.wr_addr == ADDR_WIDTH'(k)) shadow[k] <= wr.wr_data;
      end
      case (state)
        IDLE: begin
          if (commit_req) begin
            state      <= PENDING;
            wr_ready_q <= 1'b0;
            busy       <= 1'b1;
          end
        end
        PENDING: begin
          if (frame_strobe) begin
            for (int k = 0; k < NN; k++) active[k] <= shadow[k];
            state      <= ACK;
            commit_ack <= 1'b1;
            s_update   <= 1'b1;
            err_addr   <= 1'b0;
          end
        end
        ACK: begin
          state      <= IDLE;
          wr_ready_q <= 1'b1;
          busy       <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          wr_ready_q <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NN; g++) begin : g_flat
    assign s_flat[g*COEF_WIDTH +: COEF_WIDTH] = active[g];
  end

`ifdef VSN_SPARAM_COEF_READBACK_EN
  // Registered read mux over the active bank; unmapped addresses read as zero
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_data <= '0;
    end else begin
      rd_data <= '0;
      for (int k = 0; k < NN; k++)
        if (rd_addr == ADDR_WIDTH'(k)) rd_data <= active[k];
    end
  end
`endif

endmodule
